branch_predictor_bht: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It combines a direct-mapped branch target buffer with per-entry saturating counters. In IF it supplies a predicted next fetch PC from the current PC. In EX it resolves conditional branches, raises the flush on a misprediction, supplies the corrected PC, and trains the table. Depth, counter width and tag width are parameters, and an optional statistics block can be compiled in.

---
 rtl/branch_predictor_bht.sv | 132 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped branch target buffer with per-entry
// saturating direction counters. IF gets a predicted next PC from the current
// PC. EX resolves conditional branches, flags mispredictions, and trains the table.
// Optional: define BP_STATS_EN to compile in saturating branch/mispredict counters.
module branch_predictor_bht #(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IF_PC,
   output logic [31:0] IF_next_PC,
   output logic        IF_predict_taken,
   input  logic        EX_valid,
   input  logic [31:0] EX_PC,
   input  logic [31:0] EX_imm,
   input  logic [31:0] EX_pred_PC,
   input  logic        jump_taken,
   output logic [31:0] EX_next_PC,
   output logic        Predict_Flush
`ifdef BP_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   localparam int               IDX_W    = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

   // Table storage: valid and ctr are reset, tag and target are plain payload.
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             ex_write;
   logic [31:0]      branch_target;
   logic [31:0]      actual_pc;
   logic             mispredict;
   logic [CTR_W-1:0] ctr_next;

   // The low two PC bits and the bits above the tag never take part in lookup.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{IF_PC, EX_PC};

   // Prediction path: lookup on IF_PC.
   assign if_idx = IF_PC[2 +: IDX_W];
   assign if_tag = IF_PC[2 + IDX_W +: TAG_W];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   assign IF_predict_taken = !rst && if_hit && ctr_q[if_idx][CTR_W-1];
   assign IF_next_PC       = IF_predict_taken ? target_q[if_idx] : IF_PC + 32'd4;

   // Resolution path: the architecturally correct successor of the EX branch.
   assign ex_idx        = EX_PC[2 +: IDX_W];
   assign ex_tag        = EX_PC[2 + IDX_W +: TAG_W];
   assign ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign branch_target = EX_PC + EX_imm;
   assign actual_pc     = jump_taken ? branch_target : EX_PC + 32'd4;

   // A correct direction with a stale target still counts: only the PC matters.
   assign mispredict    = EX_valid && (EX_pred_PC != actual_pc);
   assign EX_next_PC    = actual_pc;
   assign Predict_Flush = !rst && mispredict;

   // Hits always train; misses only allocate when the branch was taken.
   assign ex_write = EX_valid && (ex_hit || jump_taken);

   // Next counter value: saturating step on a hit, weakly taken on allocation.
   always_comb begin
      // NOTE: default assigned first so every path drives ctr_next and no latch is inferred.
      ctr_next = CTR_WEAK;
      if (ex_hit) begin
         if (jump_taken) begin
            ctr_next = (ctr_q[ex_idx] == CTR_MAX) ? CTR_MAX : ctr_q[ex_idx] + CTR_W'(1);
         end else begin
            ctr_next = (ctr_q[ex_idx] == '0) ? '0 : ctr_q[ex_idx] - CTR_W'(1);
         end
      end
   end

   // Valid bits and counters: cleared asynchronously, trained on resolved branches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= '0;
         end
      end else if (ex_write) begin
         // NOTE: non-blocking so every flop samples pre-edge values, matching hardware.
         valid_q[ex_idx] <= 1'b1;
         ctr_q[ex_idx]   <= ctr_next;
      end
   end

   // Tag and target payload; a write landing during reset is harmless because valid stays clear.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are deliberately not reset; the valid bit qualifies every read.
      if (ex_write) begin
         tag_q[ex_idx]    <= ex_tag;
         target_q[ex_idx] <= branch_target;
      end
   end

`ifdef BP_STATS_EN
   // Saturating event counters for resolved branches and mispredictions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (EX_valid && (stat_branches != '1)) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (mispredict && (stat_mispredicts != '1)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed test-plan steps followed by randomized
// traffic, all checked against a table model kept in plain integer arithmetic.
module tb_branch_predictor_bht;

   localparam int N_ENT   = 64;
   localparam int CTR_TOP = 3;   // 2^CTR_W - 1
   localparam int CTR_THR = 2;   // 2^(CTR_W-1): at or above predicts taken

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic [31:0] if_next_pc;
   logic        if_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_pred;
   logic        jt;
   logic [31:0] ex_next_pc;
   logic        flush;
`ifdef BP_STATS_EN
   logic [31:0] st_br;
   logic [31:0] st_mp;
   int          m_br;
   int          m_mp;
`endif

   int checks = 0;
   int errors = 0;

   // Reference table.
   bit          m_valid  [N_ENT];
   int          m_tag    [N_ENT];
   logic [31:0] m_target [N_ENT];
   int          m_ctr    [N_ENT];

   branch_predictor_bht #(.ENTRIES(64), .CTR_W(2), .TAG_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .IF_PC            (if_pc),
      .IF_next_PC       (if_next_pc),
      .IF_predict_taken (if_taken),
      .EX_valid         (ex_valid),
      .EX_PC            (ex_pc),
      .EX_imm           (ex_imm),
      .EX_pred_PC       (ex_pred),
      .jump_taken       (jt),
      .EX_next_PC       (ex_next_pc),
      .Predict_Flush    (flush)
`ifdef BP_STATS_EN
      ,
      .stat_branches    (st_br),
      .stat_mispredicts (st_mp)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd64);
   endfunction

   function automatic int m_tagof(input logic [31:0] pc);
      return int'((pc >> 8) % 32'd256);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      return !rst && m_hit(pc) && (m_ctr[m_index(pc)] >= CTR_THR);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      return m_taken(pc) ? m_target[m_index(pc)] : pc + 32'd4;
   endfunction

   function automatic logic [31:0] m_actual();
      return jt ? ex_pc + ex_imm : ex_pc + 32'd4;
   endfunction

   function automatic bit m_flush();
      return !rst && ex_valid && (ex_pred != m_actual());
   endfunction

   task automatic m_clear();
      for (int i = 0; i < N_ENT; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 0;
      end
`ifdef BP_STATS_EN
      m_br = 0;
      m_mp = 0;
`endif
   endtask

   task automatic m_train();
      int i;
      i = m_index(ex_pc);
      if (!ex_valid) return;
`ifdef BP_STATS_EN
      m_br++;
      if (ex_pred != m_actual()) m_mp++;
`endif
      if (m_hit(ex_pc)) begin
         m_ctr[i]    = jt ? ((m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
         m_target[i] = ex_pc + ex_imm;
      end else if (jt) begin
         m_valid[i]  = 1'b1;
         m_tag[i]    = m_tagof(ex_pc);
         m_target[i] = ex_pc + ex_imm;
         m_ctr[i]    = CTR_THR;
      end
   endtask

   // Apply one cycle of inputs and settle to the middle of the cycle.
   task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] pred, input logic t);
      if_pc    = ipc;
      ex_valid = v;
      ex_pc    = pc;
      ex_imm   = imm;
      ex_pred  = pred;
      jt       = t;
      #4;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".if_next"}, if_next_pc, m_next(if_pc));
      check({tag, ".if_taken"}, {31'd0, if_taken}, {31'd0, m_taken(if_pc)});
      check({tag, ".ex_next"}, ex_next_pc, m_actual());
      check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush()});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) m_clear();
      else     m_train();
      #1;
   endtask

   localparam logic [31:0] IMM_M16 = 32'hFFFF_FFF0;

   initial begin
      logic [31:0] pool [8];
      pool = '{32'h40, 32'h140, 32'h80, 32'h1080, 32'h44, 32'h48, 32'h2040, 32'hFFFF_FFFC};

      // Reset held with a mismatching EX branch present.
      rst = 1'b1;
      m_clear();
      drive(32'h100, 1'b1, 32'h40, IMM_M16, 32'h0, 1'b1);
      check("rst_hold.flush", {31'd0, flush}, 32'd0);
      check("rst_hold.taken", {31'd0, if_taken}, 32'd0);
      check("rst_hold.if_next", if_next_pc, 32'h104);
      check("rst_hold.ex_next", ex_next_pc, 32'h30);
      tick();
      rst = 1'b0;

      // Reset state.
      drive(32'h100, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("reset.if_next", if_next_pc, 32'h104);
      check("reset.taken", {31'd0, if_taken}, 32'd0);
      check("reset.flush", {31'd0, flush}, 32'd0);
      tick();

      // Allocate on a taken miss.
      drive(32'h100, 1'b1, 32'h40, IMM_M16, 32'h44, 1'b1);
      check("alloc.flush", {31'd0, flush}, 32'd1);
      check("alloc.ex_next", ex_next_pc, 32'h30);
      tick();
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("alloc.if_next", if_next_pc, 32'h30);
      check("alloc.taken", {31'd0, if_taken}, 32'd1);
      tick();

      // Saturate at 3 with three more taken updates.
      for (int k = 0; k < 3; k++) begin
         drive(32'h40, 1'b1, 32'h40, IMM_M16, 32'h30, 1'b1);
         check("sat.flush", {31'd0, flush}, 32'd0);
         check_all("sat");
         tick();
      end

      // One not-taken: counter 3 -> 2, still predicts taken.
      drive(32'h40, 1'b1, 32'h40, IMM_M16, 32'h30, 1'b0);
      check("nt1.flush", {31'd0, flush}, 32'd1);
      check("nt1.ex_next", ex_next_pc, 32'h44);
      tick();
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("hyst.if_next", if_next_pc, 32'h30);
      tick();

      // Two more not-taken: counter reaches 0.
      for (int k = 0; k < 2; k++) begin
         drive(32'h40, 1'b1, 32'h40, IMM_M16, 32'h30, 1'b0);
         check_all("nt");
         tick();
      end
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("ctr0.if_next", if_next_pc, 32'h44);
      check("ctr0.taken", {31'd0, if_taken}, 32'd0);
      tick();

      // Alias replacement: 0x140 shares index 16 with 0x40.
      drive(32'h100, 1'b1, 32'h140, 32'h20, 32'h144, 1'b1);
      check("alias.flush", {31'd0, flush}, 32'd1);
      check("alias.ex_next", ex_next_pc, 32'h160);
      tick();
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("alias.old", if_next_pc, 32'h44);
      drive(32'h140, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("alias.new", if_next_pc, 32'h160);
      tick();

      // Same-cycle read and write of one entry: no bypass.
      drive(32'h40, 1'b1, 32'h40, IMM_M16, 32'h44, 1'b1);
      check("rw.same", if_next_pc, 32'h44);
      tick();
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("rw.next", if_next_pc, 32'h30);
      tick();

      // Reset mid-operation.
      drive(32'h40, 1'b1, 32'h40, IMM_M16, 32'h0, 1'b1);
      check("midrst.pre_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      #1;
      m_clear();
      check("midrst.flush", {31'd0, flush}, 32'd0);
      check("midrst.taken", {31'd0, if_taken}, 32'd0);
      check("midrst.if_next", if_next_pc, 32'h44);
`ifdef BP_STATS_EN
      check("midrst.st_br", st_br, 32'd0);
      check("midrst.st_mp", st_mp, 32'd0);
`endif
      tick();
      rst = 1'b0;
      drive(32'h40, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
      check("midrst.cleared", if_next_pc, 32'h44);
      tick();

      // Randomized traffic over a small aliasing PC pool.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] epc;
         logic [31:0] imm;
         epc = pool[$urandom_range(0, 7)];
         imm = 32'($signed($urandom_range(0, 511)) * 4 - 1024);
         if_pc    = pool[$urandom_range(0, 7)];
         ex_valid = ($urandom_range(0, 3) != 0);
         ex_pc    = epc;
         ex_imm   = imm;
         jt       = $urandom_range(0, 1) == 1;
         ex_pred  = ($urandom_range(0, 1) == 1) ? m_next(epc) : pool[$urandom_range(0, 7)];
         #4;
         check_all("rand");
         tick();
      end

`ifdef BP_STATS_EN
      check("stats.branches", st_br, 32'(m_br));
      check("stats.mispredicts", st_mp, 32'(m_mp));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
